// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared types and constants for the multi-channel tick generator
package tick_gen_pkg;

   typedef enum logic {MODE_PULSE, MODE_SQUARE} tick_mode_e;

   localparam int unsigned DEFAULT_TC_C = 999_999;
   localparam int unsigned MAX_CH_C     = 16;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/module_tick_channel.sv
// rtl/module_tick_channel.sv - one tick channel: wrap counter, shadowed TC/mode, pulse or square output
module module_tick_channel
   import tick_gen_pkg::*;
#(
   parameter int unsigned      CNT_W  = 24,
   parameter logic [CNT_W-1:0] RST_TC = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] tc_i,
   input  logic             mode_i,
   input  logic             sync_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_tc_q, act_tc_d;
   logic [CNT_W-1:0] sh_tc_q, sh_tc_d;
   tick_mode_e       act_mode_q, act_mode_d;
   tick_mode_e       sh_mode_q, sh_mode_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             wrap;

   always_comb begin
      cnt_d      = cnt_q;
      act_tc_d   = act_tc_q;
      act_mode_d = act_mode_q;
      sh_tc_d    = sh_tc_q;
      sh_mode_d  = sh_mode_q;
      pend_d     = pend_q;
      tick_d     = tick_q;
      wrap       = (cnt_q == act_tc_q);

      if (load_i) begin
         sh_tc_d   = tc_i;
         sh_mode_d = tick_mode_e'(mode_i);
         pend_d    = 1'b1;
      end

      // Idle or restarted channels take a same-edge load straight into the active set.
      if (sync_i || !enable_i) begin
         cnt_d  = '0;
         tick_d = 1'b0;
         if (pend_d) begin
            act_tc_d   = sh_tc_d;
            act_mode_d = sh_mode_d;
            pend_d     = 1'b0;
         end
      end else if (wrap) begin
         cnt_d = '0;
         // A load landing on the wrap edge itself stays pending for the next wrap.
         if (pend_q) begin
            act_tc_d   = sh_tc_q;
            act_mode_d = sh_mode_q;
            pend_d     = load_i;
         end
         if (act_mode_d == MODE_PULSE) begin
            tick_d = 1'b1;
         end else if (act_mode_q != MODE_SQUARE) begin
            tick_d = 1'b0;
         end else begin
            tick_d = ~tick_q;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (act_mode_q == MODE_PULSE) begin
            tick_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         act_tc_q   <= RST_TC;
         act_mode_q <= MODE_PULSE;
         sh_tc_q    <= RST_TC;
         sh_mode_q  <= MODE_PULSE;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         act_tc_q   <= act_tc_d;
         act_mode_q <= act_mode_d;
         sh_tc_q    <= sh_tc_d;
         sh_mode_q  <= sh_mode_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/module_tick_generator.sv
// rtl/module_tick_generator.sv - multi-channel programmable tick/clock generator top
module module_tick_generator
   import tick_gen_pkg::*;
#(
   parameter  int unsigned NUM_CH     = 4,
   parameter  int unsigned CNT_W      = 24,
   parameter  int unsigned DEFAULT_TC = DEFAULT_TC_C,
   localparam int unsigned SEL_W      = sel_width(NUM_CH)
) (
   input  logic              clk_10Mhz_i,
   input  logic              reset_n_i,
   input  logic [NUM_CH-1:0] enable_i,
   input  logic              load_i,
   input  logic [SEL_W-1:0]  ch_sel_i,
   input  logic [CNT_W-1:0]  tc_i,
   input  logic              mode_i,
   input  logic              sync_i,
   output logic [NUM_CH-1:0] tick_o
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_load;

      // Only indices below NUM_CH can match, so out-of-range selects fall through.
      assign ch_load = load_i && (ch_sel_i == SEL_W'(i));

      module_tick_channel #(
         .CNT_W  (CNT_W),
         .RST_TC (CNT_W'(DEFAULT_TC))
      ) u_ch (
         .clk      (clk_10Mhz_i),
         .rst_n    (reset_n_i),
         .enable_i (enable_i[i]),
         .load_i   (ch_load),
         .tc_i     (tc_i),
         .mode_i   (mode_i),
         .sync_i   (sync_i),
         .tick_o   (tick_o[i])
      );
   end

endmodule

// File: tb/tb_module_tick_generator.sv
// tb/tb_module_tick_generator.sv - randomized and directed bench against a period-level channel model
module tb_module_tick_generator;

   localparam int NCH = 3;
   localparam int CW  = 24;
   localparam int DTC = 39;
   localparam int SW  = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] en = '0;
   logic           load = 1'b0;
   logic [SW-1:0]  sel = '0;
   logic [CW-1:0]  tc = '0;
   logic           mode = 1'b0;
   logic           sync = 1'b0;
   logic [NCH-1:0] tick;

   module_tick_generator #(
      .NUM_CH     (NCH),
      .CNT_W      (CW),
      .DEFAULT_TC (DTC)
   ) dut (
      .clk_10Mhz_i (clk),
      .reset_n_i   (rst_n),
      .enable_i    (en),
      .load_i      (load),
      .ch_sel_i    (sel),
      .tc_i        (tc),
      .mode_i      (mode),
      .sync_i      (sync),
      .tick_o      (tick)
   );

   always #50 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Model: position within the current period, active and shadow settings,
   // number of wraps seen since square mode (re)started, and whether the last edge wrapped.
   int m_pos[NCH];
   int m_n[NCH];
   int m_sh_n[NCH];
   bit m_sq[NCH];
   bit m_sh_sq[NCH];
   bit m_pend[NCH];
   int m_wraps[NCH];
   bit m_lastwrap[NCH];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_pos[c] = 0; m_n[c] = DTC; m_sh_n[c] = DTC;
         m_sq[c] = 1'b0; m_sh_sq[c] = 1'b0; m_pend[c] = 1'b0;
         m_wraps[c] = 0; m_lastwrap[c] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < NCH; c++) begin
         bit ld;
         bit was_sq;
         ld = load && (int'(sel) == c);
         if (sync || !en[c]) begin
            if (ld) begin m_sh_n[c] = int'(tc); m_sh_sq[c] = mode; m_pend[c] = 1'b1; end
            if (m_pend[c]) begin m_n[c] = m_sh_n[c]; m_sq[c] = m_sh_sq[c]; m_pend[c] = 1'b0; end
            m_pos[c] = 0; m_wraps[c] = 0; m_lastwrap[c] = 1'b0;
         end else begin
            if (m_pos[c] == m_n[c]) begin
               was_sq = m_sq[c];
               m_pos[c] = 0;
               if (m_pend[c]) begin m_n[c] = m_sh_n[c]; m_sq[c] = m_sh_sq[c]; m_pend[c] = 1'b0; end
               if (m_sq[c]) m_wraps[c] = was_sq ? m_wraps[c] + 1 : 0;
               m_lastwrap[c] = 1'b1;
            end else begin
               m_pos[c]++;
               m_lastwrap[c] = 1'b0;
            end
            if (ld) begin m_sh_n[c] = int'(tc); m_sh_sq[c] = mode; m_pend[c] = 1'b1; end
         end
      end
   endtask

   function automatic int model_out();
      int v = 0;
      for (int c = 0; c < NCH; c++) begin
         if (m_sq[c] ? (m_wraps[c] % 2 == 1) : m_lastwrap[c]) v |= (1 << c);
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      chk("tick_o", int'(tick), model_out());
   endtask

   task automatic idle_inputs();
      en = '0; load = 1'b0; sync = 1'b0; sel = '0; tc = '0; mode = 1'b0;
   endtask

   task automatic load_ch(input int ch, input int n, input bit sq);
      load = 1'b1; sel = SW'(ch); tc = CW'(n); mode = sq;
      step();
      load = 1'b0;
   endtask

   task automatic async_reset();
      @(negedge clk);
      #10 rst_n = 1'b0;
      #5 chk("async_reset", int'(tick), 0);
      model_reset();
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [14:0] obs15;
      logic [11:0] obs12;
      logic [17:0] obs18;
      logic [5:0]  obs6;
      int first_hi;
      int hi_cnt;
      int others;

      model_reset();
      step();
      step();
      chk("reset_state", int'(tick), 0);
      rst_n = 1'b1;

      // Default terminal count on ch0.
      en = 3'b001;
      first_hi = -1; hi_cnt = 0; others = 0;
      for (int k = 0; k < 80; k++) begin
         step();
         if (tick[0]) begin hi_cnt++; if (first_hi < 0) first_hi = k; end
         others |= int'(tick[2:1]);
      end
      chk("default_first_wrap", first_hi, DTC);
      chk("default_tick_count", hi_cnt, 2);
      chk("default_others_zero", others, 0);

      // Pulse mode, N=4.
      idle_inputs(); step();
      load_ch(1, 4, 1'b0); step();
      en = 3'b010;
      for (int k = 0; k < 15; k++) begin step(); obs15[k] = tick[1]; end
      chk("pulse_n4_edges", int'(obs15), int'(15'b100001000010000));

      // Square mode, N=2, then N=0.
      idle_inputs(); step();
      load_ch(2, 2, 1'b1); step();
      en = 3'b100;
      for (int k = 0; k < 12; k++) begin step(); obs12[k] = tick[2]; end
      chk("square_n2_wave", int'(obs12), int'(12'b011100011100));
      idle_inputs(); step();
      load_ch(2, 0, 1'b1); step();
      en = 3'b100;
      for (int k = 0; k < 6; k++) begin step(); obs6[k] = tick[2]; end
      chk("square_n0_wave", int'(obs6), int'(6'b010101));
      en = 3'b000;
      step();
      chk("enable_drop", int'(tick[2]), 0);

      // Shadow update mid-period: N=9 running, load N=3 while the counter is at 5.
      idle_inputs(); step();
      load_ch(1, 9, 1'b0); step();
      en = 3'b010;
      for (int k = 0; k < 18; k++) begin
         load = (k == 5); sel = 2'd1; tc = CW'(3); mode = 1'b0;
         step();
         obs18[k] = tick[1];
      end
      load = 1'b0;
      chk("shadow_update_edges", int'(obs18), int'(18'b100010001000000000));
      load_ch(1, 7, 1'b1);
      load_ch(1, 2, 1'b0);
      for (int k = 0; k < 20; k++) step();

      // Sync with two channels running, then sync together with a load.
      idle_inputs(); step();
      load_ch(0, 6, 1'b0);
      load_ch(1, 10, 1'b0); step();
      en = 3'b011;
      for (int k = 0; k < 15; k++) step();
      sync = 1'b1; step(); sync = 1'b0;
      chk("sync_clears", int'(tick), 0);
      for (int k = 0; k < 25; k++) step();
      sync = 1'b1; load = 1'b1; sel = 2'd0; tc = CW'(2); mode = 1'b0;
      step();
      sync = 1'b0; load = 1'b0;
      first_hi = -1;
      for (int k = 0; k < 10; k++) begin step(); if (tick[0] && first_hi < 0) first_hi = k; end
      chk("sync_load_first_wrap", first_hi, 2);

      // Out-of-range channel select must leave every channel untouched.
      load = 1'b1; sel = 2'd3; tc = CW'(1); mode = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 24; k++) step();

      // Asynchronous reset with ch0 held high in N=0 pulse mode.
      load_ch(0, 0, 1'b0);
      for (int k = 0; k < 12; k++) step();
      chk("pre_reset_high", int'(tick[0]), 1);
      async_reset();

      // Randomized traffic.
      en = 3'b111;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
         load = ($urandom_range(0, 3) == 0);
         sel  = SW'($urandom_range(0, 3));
         tc   = CW'($urandom_range(0, 9));
         mode = 1'($urandom);
         sync = ($urandom_range(0, 40) == 0);
         step();
         if (i == 1500) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
